// File: rtl/qspi_rcache.sv
`default_nettype none
// ============================================================================
// Module      : qspi_rcache
// Description : Direct-mapped, read-only cache between an AXI-style read
//               port and a QSPI flash line-fill engine. Misses fetch a
//               whole line as LINE_WORDS beats; out-of-window addresses
//               return SLVERR without touching flash.
// Ports       : aclk/aresetn          clock, synchronous active-low reset
//               arvalid/arready/araddr read-address handshake
//               rvalid/rready/rdata/rresp read-data handshake
//               flush                 pulse, invalidates every line
//               qspi_req/qspi_ack/qspi_addr  line-fill request
//               qspi_dout/qspi_dval   fill data beats
//               hit_cnt/miss_cnt      saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module qspi_rcache #(
  parameter int LINES      = 256,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 24,
  parameter int CNT_W      = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              arvalid,
  output logic              arready,
  input  logic [31:0]       araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  input  logic              flush,
  output logic              qspi_req,
  input  logic              qspi_ack,
  output logic [ADDR_W-1:0] qspi_addr,
  input  logic [31:0]       qspi_dout,
  input  logic              qspi_dval,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int C_OB  = $clog2(LINE_WORDS);
  localparam int C_IB  = $clog2(LINES);
  localparam int C_TW  = ADDR_W - 2 - C_OB - C_IB;
  localparam int C_DAW = C_IB + C_OB;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_LOOKUP = 3'd2,
    S_REFILL = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  // Request fields decoded straight from the bus (used for the RAM read in
  // the handshake cycle) and their latched copies for later stages.
  logic [C_OB-1:0] w_ar_off;
  logic [C_IB-1:0] w_ar_idx;
  logic [C_TW-1:0] w_ar_tag;
  logic            w_ar_oob;
  logic            w_unused;

  logic [C_OB-1:0] r_off;
  logic [C_IB-1:0] r_idx;
  logic [C_TW-1:0] r_tag;
  logic            r_oob;

  logic [C_IB-1:0] r_init_cnt;
  logic            r_flush_pend;
  logic            r_acked;
  logic [C_OB-1:0] r_beat;

  logic [C_TW:0]   tag_ram [LINES];
  logic [31:0]     data_ram [LINES*LINE_WORDS];
  logic [C_TW:0]   r_tag_q;
  logic [31:0]     r_data_q;

  logic [C_IB-1:0]  w_tag_addr;
  logic             w_tag_we;
  logic [C_TW:0]    w_tag_wdata;
  logic [C_DAW-1:0] w_data_addr;

  logic w_hs;
  logic w_hit;
  logic w_beat;
  logic w_last;
  logic w_flush_any;

  assign w_ar_off = araddr[2 +: C_OB];
  assign w_ar_idx = araddr[2+C_OB +: C_IB];
  assign w_ar_tag = araddr[ADDR_W-1 -: C_TW];
  assign w_ar_oob = (araddr >> ADDR_W) != 32'd0;
  assign w_unused = &{1'b0, araddr[1:0]};

  // A flush request (fresh or pending) blocks new transactions.
  assign arready     = (r_state == S_IDLE) && !flush && !r_flush_pend;
  assign w_hs        = arvalid && arready;
  assign w_hit       = r_tag_q[C_TW] && (r_tag_q[C_TW-1:0] == r_tag);
  // Beats only count once the request has been acknowledged.
  assign w_beat      = (r_state == S_REFILL) && r_acked && qspi_dval;
  assign w_last      = w_beat && (&r_beat);
  assign w_flush_any = flush || r_flush_pend;

  // --------------------------------------------------------------------------
  // Single-port RAM address/write muxes
  // --------------------------------------------------------------------------
  always_comb begin
    w_tag_addr  = w_ar_idx;
    w_tag_we    = 1'b0;
    w_tag_wdata = '0;
    w_data_addr = {w_ar_idx, w_ar_off};
    if (r_state == S_INIT) begin
      w_tag_addr = r_init_cnt;
      w_tag_we   = 1'b1;
    end else if (r_state == S_REFILL) begin
      w_tag_addr  = r_idx;
      w_tag_we    = w_last;
      w_tag_wdata = {1'b1, r_tag};
      w_data_addr = {r_idx, r_beat};
    end
  end

  always_ff @(posedge aclk) begin
    if (w_tag_we) begin
      tag_ram[w_tag_addr] <= w_tag_wdata;
    end
    r_tag_q <= tag_ram[w_tag_addr];
  end

  always_ff @(posedge aclk) begin
    if (w_beat) begin
      data_ram[w_data_addr] <= qspi_dout;
    end
    r_data_q <= data_ram[w_data_addr];
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Any return to IDLE is redirected to INIT while a flush is outstanding,
  // including the end of an INIT that saw a flush arrive mid-sweep.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT: begin
        if (&r_init_cnt) begin
          w_next = w_flush_any ? S_INIT : S_IDLE;
        end
      end
      S_IDLE: begin
        if (flush) begin
          w_next = S_INIT;
        end else if (w_hs) begin
          w_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        w_next = (r_oob || w_hit) ? S_RESP : S_REFILL;
      end
      S_REFILL: begin
        if (w_last) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rready) begin
          w_next = w_flush_any ? S_INIT : S_IDLE;
        end
      end
      default: w_next = S_INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_init_cnt   <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (r_state == S_INIT) begin
        r_init_cnt <= r_init_cnt + C_IB'(1);
      end else begin
        r_init_cnt <= '0;
      end
      if (w_next == S_INIT && (r_state != S_INIT || (&r_init_cnt))) begin
        r_flush_pend <= 1'b0;
      end else if (flush && r_state != S_IDLE) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_off     <= '0;
      r_idx     <= '0;
      r_tag     <= '0;
      r_oob     <= 1'b0;
      r_acked   <= 1'b0;
      r_beat    <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rresp     <= 2'b00;
      qspi_req  <= 1'b0;
      qspi_addr <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      if (w_hs) begin
        r_off <= w_ar_off;
        r_idx <= w_ar_idx;
        r_tag <= w_ar_tag;
        r_oob <= w_ar_oob;
      end
      case (r_state)
        S_LOOKUP: begin
          if (r_oob) begin
            rvalid <= 1'b1;
            rdata  <= '0;
            rresp  <= 2'b10;
          end else if (w_hit) begin
            rvalid <= 1'b1;
            rdata  <= r_data_q;
            rresp  <= 2'b00;
            if (!(&hit_cnt)) begin
              hit_cnt <= hit_cnt + CNT_W'(1);
            end
          end else begin
            if (!(&miss_cnt)) begin
              miss_cnt <= miss_cnt + CNT_W'(1);
            end
            qspi_req  <= 1'b1;
            qspi_addr <= {r_tag, r_idx, {(C_OB+2){1'b0}}};
            r_acked   <= 1'b0;
            r_beat    <= '0;
          end
        end
        S_REFILL: begin
          if (qspi_req && qspi_ack) begin
            qspi_req <= 1'b0;
            r_acked  <= 1'b1;
          end
          if (w_beat) begin
            r_beat <= r_beat + C_OB'(1);
            if (r_beat == r_off) begin
              rdata <= qspi_dout;
            end
          end
          if (w_last) begin
            rvalid <= 1'b1;
            rresp  <= 2'b00;
          end
        end
        S_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qspi_rcache.sv
`default_nettype none
// ============================================================================
// Module      : tb_qspi_rcache
// Description : Directed self-checking bench for qspi_rcache with a simple
//               flash responder (junk beats before ack, a gap mid-burst).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qspi_rcache;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        flush;
  logic        qspi_req;
  logic        qspi_ack;
  logic [23:0] qspi_addr;
  logic [31:0] qspi_dout;
  logic        qspi_dval;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] fl_base = 32'h0;
  int          fl_req_cnt = 0;
  logic [23:0] fl_last_addr = 24'h0;

  always #5 aclk = ~aclk;

  qspi_rcache #(
    .LINES(256), .LINE_WORDS(4), .ADDR_W(24), .CNT_W(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .flush(flush),
    .qspi_req(qspi_req), .qspi_ack(qspi_ack), .qspi_addr(qspi_addr),
    .qspi_dout(qspi_dout), .qspi_dval(qspi_dval),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  // Flash responder: junk dval before ack, ack, then beats base+k with a gap.
  initial begin
    qspi_ack  = 1'b0;
    qspi_dval = 1'b0;
    qspi_dout = 32'h0;
    forever begin
      tick();
      if (qspi_req) begin
        fl_req_cnt++;
        fl_last_addr = qspi_addr;
        qspi_dval = 1'b1;
        qspi_dout = 32'hDEAD_BEEF;
        tick();
        tick();
        qspi_dval = 1'b0;
        qspi_ack  = 1'b1;
        tick();
        qspi_ack  = 1'b0;
        for (int k = 0; k < 4; k++) begin
          qspi_dval = 1'b1;
          qspi_dout = fl_base + k;
          tick();
          qspi_dval = 1'b0;
          if (k == 1) tick();
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver only: performs one read and reports what it observed.
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] d,
                          output logic [1:0] r, output int lat);
    int n;
    n = 0;
    while (!arready && n < 1000) begin
      tick();
      n++;
    end
    arvalid = 1'b1;
    araddr  = addr;
    tick();
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 100) begin
      tick();
      lat++;
    end
    d = rdata;
    r = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    aresetn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({arready, rvalid, qspi_req} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: arready/rvalid/qspi_req=%b required 000", {arready, rvalid, qspi_req});
    end
    checks++;
    if (rdata !== 32'h0 || rresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_rdata: rdata=%h rresp=%b required 0/00", rdata, rresp);
    end
    checks++;
    if (qspi_addr !== 24'h0) begin
      errors++;
      $display("FAIL reset_qaddr: %h required 0", qspi_addr);
    end
    aresetn = 1'b1;
    n = 0;
    while (!arready && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL init_len: arready after %0d cycles required 256", n);
    end
    checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: hit=%0d miss=%0d required 0/0", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_cold_miss;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    fl_base = 32'hA0;
    axi_read(32'h0000_1004, d, r, lat);
    checks++;
    if (d !== 32'hA1 || r !== 2'b00) begin
      errors++;
      $display("FAIL cold_data: rdata=%h rresp=%b required 000000a1/00", d, r);
    end
    checks++;
    if (fl_last_addr !== 24'h001000 || fl_req_cnt !== 1) begin
      errors++;
      $display("FAIL cold_req: addr=%h reqs=%0d required 001000/1", fl_last_addr, fl_req_cnt);
    end
    checks++;
    if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin
      errors++;
      $display("FAIL cold_cnt: hit=%0d miss=%0d required 0/1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_hit;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    axi_read(32'h0000_100C, d, r, lat);
    checks++;
    if (d !== 32'hA3 || r !== 2'b00) begin
      errors++;
      $display("FAIL hit_data: rdata=%h rresp=%b required 000000a3/00", d, r);
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL hit_latency: %0d cycles required 2", lat);
    end
    checks++;
    if (fl_req_cnt !== 1 || hit_cnt !== 16'd1) begin
      errors++;
      $display("FAIL hit_cnt: reqs=%0d hit=%0d required 1/1", fl_req_cnt, hit_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    axi_read(32'h0000_1000, d, r, lat);
    checks++;
    if (d !== 32'hA0) begin
      errors++;
      $display("FAIL b2b_data0: rdata=%h required 000000a0", d);
    end
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready: arready=%b rvalid=%b required 1/0", arready, rvalid);
    end
    axi_read(32'h0000_1008, d, r, lat);
    checks++;
    if (d !== 32'hA2 || lat !== 2) begin
      errors++;
      $display("FAIL b2b_data1: rdata=%h lat=%0d required 000000a2/2", d, lat);
    end
    checks++;
    if (hit_cnt !== 16'd3 || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL b2b_cnt: hit=%0d miss=%0d required 3/1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_oob;
    int   n;
    logic held;
    n = 0;
    while (!arready && n < 1000) begin
      tick();
      n++;
    end
    arvalid = 1'b1;
    araddr  = 32'h0100_0000;
    tick();
    arvalid = 1'b0;
    tick();
    checks++;
    if (rvalid !== 1'b1 || rresp !== 2'b10 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL oob_resp: rvalid=%b rresp=%b rdata=%h required 1/10/0", rvalid, rresp, rdata);
    end
    held = 1'b1;
    repeat (5) begin
      tick();
      if (rvalid !== 1'b1 || rresp !== 2'b10 || rdata !== 32'h0) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL oob_hold: outputs changed while rready low (rvalid=%b rresp=%b)", rvalid, rresp);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checks++;
    if (hit_cnt !== 16'd3 || miss_cnt !== 16'd1 || fl_req_cnt !== 1) begin
      errors++;
      $display("FAIL oob_cnt: hit=%0d miss=%0d reqs=%0d required 3/1/1", hit_cnt, miss_cnt, fl_req_cnt);
    end
  endtask

  task automatic test_conflict;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    fl_base = 32'hB0;
    axi_read(32'h0000_5004, d, r, lat);
    checks++;
    if (d !== 32'hB1 || fl_last_addr !== 24'h005000) begin
      errors++;
      $display("FAIL conf_first: rdata=%h addr=%h required 000000b1/005000", d, fl_last_addr);
    end
    fl_base = 32'hC0;
    axi_read(32'h0000_1004, d, r, lat);
    checks++;
    if (d !== 32'hC1 || fl_last_addr !== 24'h001000) begin
      errors++;
      $display("FAIL conf_second: rdata=%h addr=%h required 000000c1/001000", d, fl_last_addr);
    end
    checks++;
    if (miss_cnt !== 16'd3 || hit_cnt !== 16'd3) begin
      errors++;
      $display("FAIL conf_cnt: hit=%0d miss=%0d required 3/3", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_flush_refill;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          n;
    fl_base = 32'hD0;
    fork
      axi_read(32'h0000_2008, d, r, lat);
      begin
        int w;
        w = 0;
        while (!qspi_req && w < 50) begin
          tick();
          w++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
    join
    checks++;
    if (d !== 32'hD2 || r !== 2'b00) begin
      errors++;
      $display("FAIL flush_fill: rdata=%h rresp=%b required 000000d2/00", d, r);
    end
    n = 0;
    while (!arready && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL flush_init_len: arready after %0d cycles required 256", n);
    end
    fl_base = 32'hE0;
    axi_read(32'h0000_1004, d, r, lat);
    checks++;
    if (d !== 32'hE1 || miss_cnt !== 16'd5 || hit_cnt !== 16'd3) begin
      errors++;
      $display("FAIL flush_remiss: rdata=%h miss=%0d hit=%0d required 000000e1/5/3", d, miss_cnt, hit_cnt);
    end
  endtask

  task automatic test_flush_idle;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          n;
    arvalid = 1'b1;
    araddr  = 32'h0000_100C;
    flush   = 1'b1;
    #1;
    checks++;
    if (arready !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_arready: arready=%b required 0", arready);
    end
    tick();
    flush   = 1'b0;
    arvalid = 1'b0;
    n = 0;
    while (!arready && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 256 || rvalid !== 1'b0 || hit_cnt !== 16'd3 || miss_cnt !== 16'd5) begin
      errors++;
      $display("FAIL flush_idle_init: cycles=%0d rvalid=%b hit=%0d miss=%0d required 256/0/3/5", n, rvalid, hit_cnt, miss_cnt);
    end
    fl_base = 32'hF0;
    axi_read(32'h0000_100C, d, r, lat);
    checks++;
    if (d !== 32'hF3 || miss_cnt !== 16'd6) begin
      errors++;
      $display("FAIL flush_idle_remiss: rdata=%h miss=%0d required 000000f3/6", d, miss_cnt);
    end
  endtask

  task automatic test_reset_refill;
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          n;
    fl_base = 32'h10;
    n = 0;
    while (!arready && n < 1000) begin
      tick();
      n++;
    end
    arvalid = 1'b1;
    araddr  = 32'h0000_3000;
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!qspi_req && n < 50) begin
      tick();
      n++;
    end
    aresetn = 1'b0;
    tick();
    checks++;
    if (qspi_req !== 1'b0 || miss_cnt !== 16'd0 || hit_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_refill: qspi_req=%b hit=%0d miss=%0d required 0/0/0", qspi_req, hit_cnt, miss_cnt);
    end
    aresetn = 1'b1;
    n = 0;
    while (!arready && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 256 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_refill_init: cycles=%0d rvalid=%b required 256/0", n, rvalid);
    end
    fl_base = 32'h20;
    axi_read(32'h0000_1004, d, r, lat);
    checks++;
    if (d !== 32'h21 || miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_refill_remiss: rdata=%h miss=%0d hit=%0d required 00000021/1/0", d, miss_cnt, hit_cnt);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    arvalid = 1'b0;
    araddr  = 32'h0;
    rready  = 1'b0;
    flush   = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_oob();
    test_conflict();
    test_flush_refill();
    test_flush_idle();
    test_reset_refill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
